// File: rtl/seg_rx_frame_arbiter_if.sv
// Bundle of the per-port AXI-Stream inputs, the merged AXI-Stream output,
// the eligibility mask and the busy flag of the segment RX frame arbiter.
interface seg_rx_frame_arbiter_if #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 1024,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DEST_WIDTH = $clog2(PORTS)
);
    logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [PORTS*KEEP_WIDTH-1:0] s_axis_tkeep;
    logic [PORTS-1:0]            s_axis_tvalid;
    logic [PORTS-1:0]            s_axis_tready;
    logic [PORTS-1:0]            s_axis_tlast;
    logic [PORTS-1:0]            s_axis_tuser;
    logic [PORTS-1:0]            cfg_port_enable;

    logic [DATA_WIDTH-1:0]       m_axis_tdata;
    logic [KEEP_WIDTH-1:0]       m_axis_tkeep;
    logic                        m_axis_tvalid;
    logic                        m_axis_tready;
    logic                        m_axis_tlast;
    logic                        m_axis_tuser;
    logic [DEST_WIDTH-1:0]       m_axis_tdest;
    logic                        status_busy;

    // Traffic source / sink side (sources the input frames, sinks the merged stream).
    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output cfg_port_enable, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tuser, m_axis_tdest, status_busy
    );

    // Arbiter side.
    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  cfg_port_enable, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        output m_axis_tuser, m_axis_tdest, status_busy
    );
endinterface

// File: rtl/seg_rx_frame_arbiter.sv
// Round-robin frame arbiter: merges PORTS AXI-Stream inputs into one stream,
// locking the grant to a port for a whole frame and registering the output beat.
module seg_rx_frame_arbiter #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 1024,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DEST_WIDTH = $clog2(PORTS)
) (
    input logic                 clk,
    input logic                 rst,
    seg_rx_frame_arbiter_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StActive} state_t;

    state_t                state;
    logic [DEST_WIDTH-1:0] grant;
    logic [DEST_WIDTH-1:0] last_grant;
    logic [DEST_WIDTH-1:0] next_grant;
    logic [DEST_WIDTH-1:0] cand;
    logic                  found;
    logic [PORTS-1:0]      eligible;
    logic                  out_free;
    logic                  accept;

    assign eligible = bus.s_axis_tvalid & bus.cfg_port_enable;
    // Output register can take a beat when empty or draining this cycle.
    assign out_free = !bus.m_axis_tvalid || bus.m_axis_tready;
    assign accept   = (state == StActive) && out_free && bus.s_axis_tvalid[grant];
    assign bus.status_busy = (state == StActive);

    // Round-robin pick: first eligible port after last_grant, wrapping modulo PORTS.
    always_comb begin
        next_grant = last_grant;
        cand       = '0;
        found      = 1'b0;
        for (int k = 1; k <= PORTS; k++) begin
            cand = DEST_WIDTH'((int'(last_grant) + k) % PORTS);
            if (!found && eligible[cand]) begin
                found      = 1'b1;
                next_grant = cand;
            end
        end
    end

    // Only the granted port sees ready, and only while a frame is active.
    always_comb begin
        bus.s_axis_tready = '0;
        if ((state == StActive) && out_free) begin
            bus.s_axis_tready[grant] = 1'b1;
        end
    end

    // Arbitration FSM plus the single output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= StIdle;
            grant             <= '0;
            last_grant        <= DEST_WIDTH'(PORTS - 1);
            bus.m_axis_tvalid <= 1'b0;
            bus.m_axis_tdata  <= '0;
            bus.m_axis_tkeep  <= '0;
            bus.m_axis_tlast  <= 1'b0;
            bus.m_axis_tuser  <= 1'b0;
            bus.m_axis_tdest  <= '0;
        end else begin
            // Drain; overridden below when a new beat is accepted in the same cycle.
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                bus.m_axis_tvalid <= 1'b0;
            end
            case (state)
                StIdle: begin
                    if (found) begin
                        grant <= next_grant;
                        state <= StActive;
                    end
                end
                StActive: begin
                    if (accept) begin
                        bus.m_axis_tdata  <= bus.s_axis_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
                        bus.m_axis_tkeep  <= bus.s_axis_tkeep[grant*KEEP_WIDTH +: KEEP_WIDTH];
                        bus.m_axis_tlast  <= bus.s_axis_tlast[grant];
                        bus.m_axis_tuser  <= bus.s_axis_tuser[grant];
                        bus.m_axis_tdest  <= grant;
                        bus.m_axis_tvalid <= 1'b1;
                        // End of frame: release the grant, one idle cycle to re-arbitrate.
                        if (bus.s_axis_tlast[grant]) begin
                            state      <= StIdle;
                            last_grant <= grant;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_rx_frame_arbiter.sv
// Directed bench for seg_rx_frame_arbiter: a cycle table for round-robin order,
// back-to-back single-beat frames and the enable mask, plus hand sequences for
// output stall, mid-frame valid drop and mid-frame reset.
module tb_seg_rx_frame_arbiter;

    localparam int PORTS = 4;
    localparam int DW    = 16;
    localparam int KW    = 2;
    localparam int DESTW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seg_rx_frame_arbiter_if #(
        .PORTS(PORTS), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEST_WIDTH(DESTW)
    ) bus ();

    seg_rx_frame_arbiter #(
        .PORTS(PORTS), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEST_WIDTH(DESTW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic       pre;   // reset before applying this row
        logic [3:0] en;
        logic [3:0] tv;
        logic [3:0] tl;
        logic [3:0] tu;
        logic       mr;
        logic [3:0] erdy;
        logic       emv;
        logic [1:0] edest;
        logic       elast;
        logic       euser;
        logic       ebusy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk_row(logic pre, logic [3:0] en, logic [3:0] tv, logic [3:0] tl,
                                    logic [3:0] tu, logic mr, logic [3:0] erdy, logic emv,
                                    logic [1:0] edest, logic elast, logic euser, logic ebusy);
        vec_t v;
        v.pre = pre; v.en = en; v.tv = tv; v.tl = tl; v.tu = tu; v.mr = mr;
        v.erdy = erdy; v.emv = emv; v.edest = edest; v.elast = elast; v.euser = euser;
        v.ebusy = ebusy;
        return v;
    endfunction

    // Beat payload tags the source port in the top nibble and a sequence number below.
    function automatic logic [DW-1:0] mk_data(int p, int beat);
        return {4'(p), 12'(beat)};
    endfunction

    function automatic logic [KW-1:0] keep_of(int p);
        logic [KW-1:0] k;
        k = 2'(p);
        return k ^ 2'b10;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic l, input logic u,
                            input int beat);
        bus.s_axis_tvalid[p]          = v;
        bus.s_axis_tlast[p]           = l;
        bus.s_axis_tuser[p]           = u;
        bus.s_axis_tdata[p*DW +: DW]  = mk_data(p, beat);
        bus.s_axis_tkeep[p*KW +: KW]  = keep_of(p);
    endtask

    task automatic clear_inputs();
        bus.s_axis_tdata    = '0;
        bus.s_axis_tkeep    = '0;
        bus.s_axis_tvalid   = '0;
        bus.s_axis_tlast    = '0;
        bus.s_axis_tuser    = '0;
        bus.cfg_port_enable = 4'hF;
        bus.m_axis_tready   = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b;
        int got;
        int stalls;
        int b0;
        int b3;
        int drop;
        logic v0;
        int        got_dest[$];
        logic [DW-1:0] got_data[$];
        int        exp_dest[4];
        logic [DW-1:0] exp_data[4];

        // ---------------- reset values (ports requesting throughout reset) -------------
        clear_inputs();
        rst = 1'b1;
        bus.s_axis_tvalid = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.s_axis_tvalid = 4'h0;
        @(negedge clk);
        chk("reset tvalid", bus.m_axis_tvalid, 0);
        chk("reset tdata", bus.m_axis_tdata, 0);
        chk("reset tkeep", bus.m_axis_tkeep, 0);
        chk("reset tlast", bus.m_axis_tlast, 0);
        chk("reset tuser", bus.m_axis_tuser, 0);
        chk("reset tdest", bus.m_axis_tdest, 0);
        chk("reset busy", bus.status_busy, 0);
        chk("reset s_tready", bus.s_axis_tready, 0);
        next_cycle();

        // ---------------- cycle table ----------------
        // Round robin, all ports valid, 2-beat frames: dest 0,1,2,3,0.
        tbl.push_back(mk_row(1, 4'hF, 4'hF, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(mk_row(0, 4'hF, 4'hF, 4'h0, 4'h0, 1, 4'h1, 0, 0, 0, 0, 1));
        tbl.push_back(mk_row(0, 4'hF, 4'hF, 4'h1, 4'h0, 1, 4'h1, 1, 0, 0, 0, 1));
        tbl.push_back(mk_row(0, 4'hF, 4'hF, 4'h0, 4'h0, 1, 4'h0, 1, 0, 1, 0, 0));
        tbl.push_back(mk_row(0, 4'hF, 4'hF, 4'h0, 4'h0, 1, 4'h2, 0, 0, 0, 0, 1));
        tbl.push_back(mk_row(0, 4'hF, 4'hF, 4'h2, 4'hA, 1, 4'h2, 1, 1, 0, 0, 1));
        tbl.push_back(mk_row(0, 4'hF, 4'hF, 4'h0, 4'h0, 1, 4'h0, 1, 1, 1, 1, 0));
        tbl.push_back(mk_row(0, 4'hF, 4'hF, 4'h0, 4'h0, 1, 4'h4, 0, 0, 0, 0, 1));
        tbl.push_back(mk_row(0, 4'hF, 4'hF, 4'h4, 4'hB, 1, 4'h4, 1, 2, 0, 0, 1));
        tbl.push_back(mk_row(0, 4'hF, 4'hF, 4'h0, 4'h0, 1, 4'h0, 1, 2, 1, 0, 0));
        tbl.push_back(mk_row(0, 4'hF, 4'hF, 4'h0, 4'h0, 1, 4'h8, 0, 0, 0, 0, 1));
        tbl.push_back(mk_row(0, 4'hF, 4'hF, 4'h8, 4'h0, 1, 4'h8, 1, 3, 0, 0, 1));
        tbl.push_back(mk_row(0, 4'hF, 4'hF, 4'h0, 4'h0, 1, 4'h0, 1, 3, 1, 0, 0));
        tbl.push_back(mk_row(0, 4'hF, 4'hF, 4'h0, 4'h0, 1, 4'h1, 0, 0, 0, 0, 1));
        tbl.push_back(mk_row(0, 4'hF, 4'hF, 4'h1, 4'h0, 1, 4'h1, 1, 0, 0, 0, 1));
        tbl.push_back(mk_row(0, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h0, 1, 0, 1, 0, 0));
        tbl.push_back(mk_row(0, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 0));
        // Port 2 alone, three 1-beat frames: valid pattern 1,0,1,0,1.
        tbl.push_back(mk_row(0, 4'hF, 4'h4, 4'h4, 4'h0, 1, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(mk_row(0, 4'hF, 4'h4, 4'h4, 4'h0, 1, 4'h4, 0, 0, 0, 0, 1));
        tbl.push_back(mk_row(0, 4'hF, 4'h4, 4'h4, 4'h0, 1, 4'h0, 1, 2, 1, 0, 0));
        tbl.push_back(mk_row(0, 4'hF, 4'h4, 4'h4, 4'h4, 1, 4'h4, 0, 0, 0, 0, 1));
        tbl.push_back(mk_row(0, 4'hF, 4'h4, 4'h4, 4'h0, 1, 4'h0, 1, 2, 1, 1, 0));
        tbl.push_back(mk_row(0, 4'hF, 4'h4, 4'h4, 4'h0, 1, 4'h4, 0, 0, 0, 0, 1));
        tbl.push_back(mk_row(0, 4'hF, 4'h0, 4'h4, 4'h0, 1, 4'h0, 1, 2, 1, 0, 0));
        tbl.push_back(mk_row(0, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 0));
        // Enable mask 1011 after reset: dest 0,1,3,0, port 2 never granted.
        tbl.push_back(mk_row(1, 4'hB, 4'hF, 4'hF, 4'h0, 1, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(mk_row(0, 4'hB, 4'hF, 4'hF, 4'h0, 1, 4'h1, 0, 0, 0, 0, 1));
        tbl.push_back(mk_row(0, 4'hB, 4'hF, 4'hF, 4'h0, 1, 4'h0, 1, 0, 1, 0, 0));
        tbl.push_back(mk_row(0, 4'hB, 4'hF, 4'hF, 4'h0, 1, 4'h2, 0, 0, 0, 0, 1));
        tbl.push_back(mk_row(0, 4'hB, 4'hF, 4'hF, 4'h0, 1, 4'h0, 1, 1, 1, 0, 0));
        tbl.push_back(mk_row(0, 4'hB, 4'hF, 4'hF, 4'h0, 1, 4'h8, 0, 0, 0, 0, 1));
        tbl.push_back(mk_row(0, 4'hB, 4'hF, 4'hF, 4'h0, 1, 4'h0, 1, 3, 1, 0, 0));
        tbl.push_back(mk_row(0, 4'hB, 4'hF, 4'hF, 4'h0, 1, 4'h1, 0, 0, 0, 0, 1));
        tbl.push_back(mk_row(0, 4'hB, 4'h0, 4'hF, 4'h0, 1, 4'h0, 1, 0, 1, 0, 0));
        tbl.push_back(mk_row(0, 4'hB, 4'h0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 0));

        // Every port drives mk_data(port, row); with tready held high the beat shown
        // on row i was accepted on row i-1.
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].pre) do_reset();
            bus.cfg_port_enable = tbl[i].en;
            bus.m_axis_tready   = tbl[i].mr;
            for (int p = 0; p < PORTS; p++) begin
                set_port(p, tbl[i].tv[p], tbl[i].tl[p], tbl[i].tu[p], i);
            end
            @(negedge clk);
            chk($sformatf("row%0d s_tready", i), bus.s_axis_tready, tbl[i].erdy);
            chk($sformatf("row%0d m_tvalid", i), bus.m_axis_tvalid, tbl[i].emv);
            chk($sformatf("row%0d busy", i), bus.status_busy, tbl[i].ebusy);
            if (tbl[i].emv) begin
                chk($sformatf("row%0d tdest", i), bus.m_axis_tdest, tbl[i].edest);
                chk($sformatf("row%0d tlast", i), bus.m_axis_tlast, tbl[i].elast);
                chk($sformatf("row%0d tuser", i), bus.m_axis_tuser, tbl[i].euser);
                chk($sformatf("row%0d tdata", i), bus.m_axis_tdata,
                    mk_data(int'(tbl[i].edest), i - 1));
                chk($sformatf("row%0d tkeep", i), bus.m_axis_tkeep,
                    keep_of(int'(tbl[i].edest)));
            end
            next_cycle();
        end

        // ---------------- port 1, 4 beats, output stalled 3 cycles mid-frame ----------
        // Port 1's enable is also cleared after its first beat; the frame must complete.
        do_reset();
        b = 0;
        got = 0;
        stalls = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            bus.m_axis_tready   = !(cyc >= 4 && cyc < 7);
            bus.cfg_port_enable = (b == 0) ? 4'hF : 4'hD;
            set_port(1, b < 4, b == 3, 1'b0, b);
            @(negedge clk);
            if (bus.m_axis_tvalid) begin
                chk("stall tdest", bus.m_axis_tdest, 1);
                chk("stall tdata", bus.m_axis_tdata, mk_data(1, got));
                chk("stall tlast", bus.m_axis_tlast, got == 3);
                if (!bus.m_axis_tready) begin
                    stalls++;
                    chk("stall s_tready", bus.s_axis_tready, 0);
                end else begin
                    got++;
                end
            end
            if (bus.s_axis_tvalid[1] && bus.s_axis_tready[1]) b++;
            next_cycle();
        end
        chk("stall beats delivered", got, 4);
        chk("stall cycles held", stalls, 3);
        clear_inputs();

        // ---------------- port 0 valid gap, port 3 waiting ----------------
        do_reset();
        b0 = 0;
        b3 = 0;
        drop = 0;
        for (int cyc = 0; cyc < 60 && got_dest.size() < 4; cyc++) begin
            v0 = (b0 < 3) && !(b0 == 1 && drop < 5);
            set_port(0, v0, b0 == 2, 1'b0, b0);
            set_port(3, b3 < 1, 1'b1, 1'b0, b3);
            @(negedge clk);
            if (b0 < 3) chk("gap port3 blocked", bus.s_axis_tready[3], 0);
            if (!v0 && b0 == 1) chk("gap busy", bus.status_busy, 1);
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                got_dest.push_back(int'(bus.m_axis_tdest));
                got_data.push_back(bus.m_axis_tdata);
            end
            if (bus.s_axis_tvalid[0] && bus.s_axis_tready[0]) b0++;
            else if (b0 == 1 && !v0) drop++;
            if (bus.s_axis_tvalid[3] && bus.s_axis_tready[3]) b3++;
            next_cycle();
        end
        exp_dest = '{0, 0, 0, 3};
        exp_data[0] = mk_data(0, 0);
        exp_data[1] = mk_data(0, 1);
        exp_data[2] = mk_data(0, 2);
        exp_data[3] = mk_data(3, 0);
        chk("gap beat count", got_dest.size(), 4);
        for (int k = 0; k < got_dest.size() && k < 4; k++) begin
            chk($sformatf("gap dest%0d", k), got_dest[k], exp_dest[k]);
            chk($sformatf("gap data%0d", k), got_data[k], exp_data[k]);
        end
        chk("gap drop cycles", drop, 5);
        clear_inputs();

        // ---------------- reset on 2nd beat of a 3-beat frame ----------------
        do_reset();
        set_port(2, 1'b1, 1'b1, 1'b0, 0);       // one full frame leaves last_grant=2
        next_cycle();
        @(negedge clk);
        chk("rst pre s_tready", bus.s_axis_tready, 4'h4);
        next_cycle();
        set_port(2, 1'b1, 1'b0, 1'b0, 1);       // idle arbitration, re-grant port 2
        next_cycle();
        @(negedge clk);
        chk("rst beat1 s_tready", bus.s_axis_tready, 4'h4);
        next_cycle();
        set_port(2, 1'b1, 1'b0, 1'b0, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst beat1 out", bus.m_axis_tdata, mk_data(2, 1));
        next_cycle();
        rst = 1'b0;
        set_port(2, 1'b0, 1'b0, 1'b0, 0);
        set_port(0, 1'b1, 1'b1, 1'b0, 7);
        set_port(3, 1'b1, 1'b1, 1'b0, 7);
        @(negedge clk);
        chk("rst after m_tvalid", bus.m_axis_tvalid, 0);
        chk("rst after busy", bus.status_busy, 0);
        chk("rst after s_tready", bus.s_axis_tready, 0);
        next_cycle();
        @(negedge clk);
        chk("rst regrant s_tready", bus.s_axis_tready, 4'h1);
        chk("rst regrant busy", bus.status_busy, 1);
        next_cycle();
        set_port(0, 1'b0, 1'b0, 1'b0, 0);
        set_port(3, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("rst regrant m_tvalid", bus.m_axis_tvalid, 1);
        chk("rst regrant tdest", bus.m_axis_tdest, 0);
        chk("rst regrant tdata", bus.m_axis_tdata, mk_data(0, 7));
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_rx_frame_arbiter.md
SEG_RX_FRAME_ARBITER -- requirements
Module: seg_rx_frame_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 4, number of AXIS input ports (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 1024, tdata width.
REQ-003 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, tkeep width.
REQ-004 SHALL have parameter DEST_WIDTH, default $clog2(PORTS), tdest width.
REQ-005 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-006 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-007 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port: s_axis_tdata  input  PORTS*DATA_WIDTH  packed per-port data; port i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port: s_axis_tkeep  input  PORTS*KEEP_WIDTH  packed per-port keep.
REQ-010 SHALL have port: s_axis_tvalid  input  PORTS  per-port valid.
REQ-011 SHALL have port: s_axis_tready  output  PORTS  per-port ready.
REQ-012 SHALL have port: s_axis_tlast  input  PORTS  per-port last.
REQ-013 SHALL have port: s_axis_tuser  input  PORTS  per-port error flag.
REQ-014 SHALL have port: cfg_port_enable  input  PORTS  arbitration eligibility mask.
REQ-015 SHALL have port: m_axis_tdata  output  DATA_WIDTH  merged data.
REQ-016 SHALL have port: m_axis_tkeep  output  KEEP_WIDTH  merged keep.
REQ-017 SHALL have port: m_axis_tvalid  output  1  merged valid.
REQ-018 SHALL have port: m_axis_tready  input  1  downstream ready.
REQ-019 SHALL have port: m_axis_tlast  output  1  merged last.
REQ-020 SHALL have port: m_axis_tuser  output  1  merged error flag.
REQ-021 SHALL have port: m_axis_tdest  output  DEST_WIDTH  index of source port of current beat.
REQ-022 SHALL have port: status_busy  output  1  high while a frame is granted.

Function
REQ-023 SHALL implement FSM with states IDLE and ACTIVE; registers grant (DEST_WIDTH) and last_grant (DEST_WIDTH).
REQ-024 In IDLE, eligible = s_axis_tvalid & cfg_port_enable; if nonzero, SHALL select first eligible index searching last_grant+1, +2, ... modulo PORTS, load grant, go ACTIVE next cycle.
REQ-025 In IDLE, all s_axis_tready bits SHALL be 0.
REQ-026 In ACTIVE, s_axis_tready[grant] SHALL equal (!m_axis_tvalid || m_axis_tready); all other ready bits 0.
REQ-027 Output SHALL be one register stage: on accepted input beat, m_axis_* load port grant fields, m_axis_tdest <= grant, m_axis_tvalid <= 1.
REQ-028 When m_axis_tvalid && m_axis_tready and no new beat accepted same cycle, m_axis_tvalid SHALL go 0 next cycle; accept-and-drain same cycle keeps m_axis_tvalid 1 (full throughput).
REQ-029 m_axis_* SHALL hold stable while m_axis_tvalid && !m_axis_tready.
REQ-030 Accepted beat with tlast=1 SHALL move FSM to IDLE next cycle and set last_grant <= grant; one idle arbitration cycle between frames.
REQ-031 Grant SHALL stay locked to one port until its tlast beat; frames never interleave on output.
REQ-032 Clearing cfg_port_enable bit of granted port mid-frame SHALL NOT abort the frame; it only blocks future grants.
REQ-033 Granted port dropping s_axis_tvalid mid-frame SHALL keep grant (wait, no timeout).
REQ-034 Latency: s_axis_tvalid rises at cycle N in IDLE -> ready at N+1 -> m_axis_tvalid at N+2 (if m_axis_tready=1).
REQ-035 status_busy SHALL be 1 exactly when FSM is ACTIVE.
REQ-036 Single eligible port SHALL be re-granted repeatedly regardless of last_grant.

Reset
REQ-037 On rst=1 at a clock edge: FSM=IDLE, grant=0, last_grant=PORTS-1 (port 0 wins first), m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdest=0, status_busy=0, s_axis_tready=0.
REQ-038 rst mid-frame SHALL discard the partial frame and pending output beat; no beat emitted on cycle after reset.

Verification
REQ-039 After reset, ports 0..3 all valid with 2-beat frames, m_axis_tready=1 -> output dest order 0,1,2,3,0; each frame's 2 beats contiguous, tlast on 2nd.
REQ-040 Port 2 only, 3 back-to-back 1-beat frames -> dest=2 each; m_axis_tvalid pattern 1,0,1,0,1 (idle arbitration cycle between frames).
REQ-041 Port 1 frame of 4 beats, m_axis_tready low 3 cycles mid-frame -> beat held stable, s_axis_tready[1]=0 while stalled, no beat lost or duplicated.
REQ-042 cfg_port_enable=4'b1011, all ports valid -> port 2 never granted; dest sequence 0,1,3,0.
REQ-043 Port 0 valid drops for 5 cycles mid-frame while port 3 valid -> port 3 not granted until port 0 tlast accepted.
REQ-044 rst asserted on 2nd beat of 3-beat frame -> next cycle m_axis_tvalid=0, status_busy=0; subsequent grant starts at port 0.
